mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of Execute: takes ALU address, store data and destination
//  register, performs byte/half/word loads and stores over a req/ack data-memory port, and
//  delivers a registered result to writeback. Stalls upstream while a bus access is open;
//  flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT   64  max cycles in ACCESS waiting for DMemAck before BusError (>=1)
// PORTS
//  Clk             in   1   clock, all state on rising edge
//  Reset           in   1   asynchronous, active-high reset
//  ExValid         in   1   upstream presents a valid instruction this cycle
//  Flush           in   1   discard the instruction presented this cycle (not yet accepted)
//  ALUResult       in   32  effective address (mem op) or result (non-mem op)
//  StoreData       in   32  rt value for stores
//  WriteRegister   in   5   destination register
//  RegWrite        in   1   instruction writes a register
//  MemRead         in   1   load
//  MemWrite        in   1   store (wins if MemRead also high)
//  MemSize         in   2   00 byte, 01 half, 10/11 word
//  MemSigned       in   1   1 = sign-extend load, 0 = zero-extend
//  Stall           out  1   upstream must hold all inputs this cycle
//  DMemReq         out  1   access request, held until ack or timeout
//  DMemWe          out  1   1 = write
//  DMemAddr        out  32  word-aligned address ({ALUResult[31:2],2'b00})
//  DMemWData       out  32  lane-replicated store data
//  DMemByteEn      out  4   byte lanes, bit i = byte addr[1:0]==i (little-endian)
//  DMemRData       in   32  read data, valid when DMemAck=1
//  DMemAck         in   1   access complete
//  WbValid         out  1   writeback fields valid (1-cycle pulse per instruction)
//  WbRegWrite      out  1   write WbData to WbWriteRegister
//  WbWriteRegister out  5   destination register
//  WbData          out  32  result (extended load data or ALUResult)
//  MisalignFault   out  1   1-cycle pulse with WbValid for misaligned mem op
//  BusError        out  1   1-cycle pulse with WbValid on ack timeout
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, all outputs 0 immediately (DMemReq drops asynchronously).
//  - FSM IDLE/ACCESS. Stall = (state==ACCESS). Accept = IDLE & ExValid & ~Flush.
//  - Non-mem op accepted (MemRead=MemWrite=0): next cycle WbValid=1, WbData=ALUResult,
//    WbRegWrite=RegWrite. Latency 1, throughput 1/cycle, stays IDLE.
//  - Mem op accepted: alignment check (half: addr[0]==0; word: addr[1:0]==0).
//    Misaligned -> no bus request; next cycle WbValid=1, WbRegWrite=0, MisalignFault=1; stay IDLE.
//    Aligned -> latch addr/data/size/sign/reg; ACCESS next cycle.
//  - ACCESS: DMemReq=1, DMemWe, DMemAddr, DMemWData, DMemByteEn registered and stable until exit.
//    DMemAck sampled high at edge -> IDLE; WbValid=1 next cycle. Min mem-op latency accept->WbValid
//    = 2 cycles with same-cycle ack; one bubble to the following instruction.
//  - Store lanes: sb BE=1<<addr[1:0], WData={4{d[7:0]}}; sh BE=addr[1]?1100:0011,
//    WData={2{d[15:0]}}; sw BE=1111, WData=d. Stores: WbRegWrite=0 regardless of RegWrite.
//  - Load extract: lane byte addr[1:0] / half addr[1]; extend per MemSigned to 32 bits;
//    word unchanged. DMemByteEn driven as for stores (informational on reads).
//  - Timeout: counter clears on entry to ACCESS, increments each ACCESS cycle without ack; at
//    count==TIMEOUT-1 without ack -> DMemReq drops, IDLE, next cycle WbValid=1, WbRegWrite=0,
//    BusError=1. Ack in same cycle as final count wins (normal completion).
//  - Flush only squashes the unaccepted input; an open access always completes on the bus.
//  - WbValid=0 cycles: WbRegWrite, MisalignFault, BusError forced 0; other Wb fields hold.
//  - Reset mid-ACCESS: abandon access, no writeback; late DMemAck after reset is ignored.
// TESTING
//  1 Reset asserted mid-ACCESS -> DMemReq=0 same cycle, WbValid=0, state IDLE; late ack ignored.
//  2 Non-mem ALUResult=0x12345678, WriteRegister=5, RegWrite=1 -> next cycle WbValid=1,
//    WbData=0x12345678, WbWriteRegister=5.
//  3 lb addr=0x103, MemSigned=1, DMemRData=0x80AABBCC, ack after 3 cycles -> DMemAddr=0x100,
//    BE=1000, Stall high 4 cycles, WbData=0xFFFFFF80; repeat MemSigned=0 -> 0x00000080.
//  4 sh addr=0x202, StoreData=0x0000BEEF -> DMemWe=1, BE=1100, WData=0xBEEFBEEF, WbRegWrite=0.
//  5 lw addr=0x106 -> no DMemReq, next cycle WbValid=1, MisalignFault=1, WbRegWrite=0.
//  6 lw addr=0x300, ack never -> after TIMEOUT ACCESS cycles DMemReq=0, BusError=1 one cycle,
//    following instruction accepted next cycle; Flush on accept cycle -> no WbValid for it.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage between Execute and Writeback: byte/half/word loads and stores over a
// req/ack data-memory port, with misalignment and bus-timeout reporting.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ExValid,
    input  logic        Flush,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic [4:0]  WriteRegister,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        Stall,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic [3:0]  DMemByteEn,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic        WbValid,
    output logic        WbRegWrite,
    output logic [4:0]  WbWriteRegister,
    output logic [31:0] WbData,
    output logic        MisalignFault,
    output logic        BusError
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [1:0]     lo_q, lo_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     size_q, size_d;
    logic           signed_q, signed_d;
    logic [4:0]     rd_q, rd_d;
    logic           rw_q, rw_d;
    logic           wb_valid_q, wb_valid_d;
    logic           wb_regwrite_q, wb_regwrite_d;
    logic [4:0]     wb_reg_q, wb_reg_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic           misalign_q, misalign_d;
    logic           buserr_q, buserr_d;

    logic           accept;
    logic           is_mem;
    logic           misaligned;
    logic [3:0]     st_be;
    logic [31:0]    st_wdata;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;

    // Lane steering for the incoming op; byte enables are also driven on loads
    always_comb begin
        misaligned = 1'b0;
        st_be      = 4'b1111;
        st_wdata   = StoreData;
        case (MemSize)
            2'b00: begin
                st_be    = 4'b0001 << ALUResult[1:0];
                st_wdata = {4{StoreData[7:0]}};
            end
            2'b01: begin
                misaligned = ALUResult[0];
                st_be      = ALUResult[1] ? 4'b1100 : 4'b0011;
                st_wdata   = {2{StoreData[15:0]}};
            end
            default: misaligned = |ALUResult[1:0];
        endcase
    end

    always_comb begin
        ld_byte = DMemRData[7:0];
        case (lo_q)
            2'b00:   ld_byte = DMemRData[7:0];
            2'b01:   ld_byte = DMemRData[15:8];
            2'b10:   ld_byte = DMemRData[23:16];
            default: ld_byte = DMemRData[31:24];
        endcase
        ld_half = lo_q[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (size_q)
            2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = DMemRData;
        endcase
    end

    assign accept = (state_q == IDLE) && ExValid && !Flush;
    assign is_mem = MemRead || MemWrite;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        lo_d          = lo_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        signed_d      = signed_q;
        rd_d          = rd_q;
        rw_d          = rw_q;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_reg_d      = wb_reg_q;
        wb_data_d     = wb_data_q;
        misalign_d    = 1'b0;
        buserr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_regwrite_d = RegWrite;
                        wb_reg_d      = WriteRegister;
                        wb_data_d     = ALUResult;
                    end else if (misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_reg_d   = WriteRegister;
                        misalign_d = 1'b1;
                    end else begin
                        state_d  = ACCESS;
                        cnt_d    = '0;
                        addr_d   = {ALUResult[31:2], 2'b00};
                        lo_d     = ALUResult[1:0];
                        we_d     = MemWrite;
                        be_d     = st_be;
                        wdata_d  = st_wdata;
                        size_d   = MemSize;
                        signed_d = MemSigned;
                        rd_d     = WriteRegister;
                        rw_d     = RegWrite && !MemWrite;
                    end
                end
            end
            ACCESS: begin
                // Ack on the final count still completes normally
                if (DMemAck) begin
                    state_d       = IDLE;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = rw_q;
                    wb_reg_d      = rd_q;
                    wb_data_d     = we_q ? {addr_q[31:2], lo_q} : ld_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = rd_q;
                    buserr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            lo_q          <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            rd_q          <= '0;
            rw_q          <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_reg_q      <= '0;
            wb_data_q     <= '0;
            misalign_q    <= 1'b0;
            buserr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            lo_q          <= lo_d;
            we_q          <= we_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            rd_q          <= rd_d;
            rw_q          <= rw_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_reg_q      <= wb_reg_d;
            wb_data_q     <= wb_data_d;
            misalign_q    <= misalign_d;
            buserr_q      <= buserr_d;
        end
    end

    assign Stall           = (state_q == ACCESS);
    assign DMemReq         = (state_q == ACCESS);
    assign DMemWe          = we_q;
    assign DMemAddr        = addr_q;
    assign DMemWData       = wdata_q;
    assign DMemByteEn      = be_q;
    assign WbValid         = wb_valid_q;
    assign WbRegWrite      = wb_regwrite_q;
    assign WbWriteRegister = wb_reg_q;
    assign WbData          = wb_data_q;
    assign MisalignFault   = misalign_q;
    assign BusError        = buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: non-mem passthrough, loads, stores, misalignment,
// bus timeout, flush and reset during an open access.
module tb_mem_access_stage;

    localparam int unsigned TO = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ExValid = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic [4:0]  WriteRegister = '0;
    logic        RegWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = '0;
    logic        MemSigned = 1'b0;
    logic        Stall;
    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemRData = '0;
    logic        DMemAck = 1'b0;
    logic        WbValid;
    logic        WbRegWrite;
    logic [4:0]  WbWriteRegister;
    logic [31:0] WbData;
    logic        MisalignFault;
    logic        BusError;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .ExValid(ExValid), .Flush(Flush),
        .ALUResult(ALUResult), .StoreData(StoreData), .WriteRegister(WriteRegister),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .Stall(Stall),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .DMemByteEn(DMemByteEn), .DMemRData(DMemRData),
        .DMemAck(DMemAck), .WbValid(WbValid), .WbRegWrite(WbRegWrite),
        .WbWriteRegister(WbWriteRegister), .WbData(WbData),
        .MisalignFault(MisalignFault), .BusError(BusError)
    );

    always #5 Clk = ~Clk;

    // {WbValid, WbRegWrite, MisalignFault, BusError, WbWriteRegister, WbData}
    function automatic logic [40:0] wb_now();
        return {WbValid, WbRegWrite, MisalignFault, BusError, WbWriteRegister, WbData};
    endfunction

    // {DMemReq, DMemWe, DMemByteEn, DMemAddr, DMemWData}
    function automatic logic [69:0] bus_now();
        return {DMemReq, DMemWe, DMemByteEn, DMemAddr, DMemWData};
    endfunction

    task automatic set_op(input logic v, input logic fl, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic [1:0] sz,
                          input logic sg);
        ExValid = v; Flush = fl; ALUResult = alu; StoreData = sd; WriteRegister = rd;
        RegWrite = rw; MemRead = mr; MemWrite = mw; MemSize = sz; MemSigned = sg;
    endtask

    // Called on a falling edge; returns on the falling edge after Stall drops.
    task automatic run_access(input logic [31:0] alu, input logic [31:0] sd,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic mw, input logic [1:0] sz, input logic sg,
                              input logic [31:0] rdata, input int ack_at,
                              output int stalls, output logic [69:0] bus);
        set_op(1'b1, 1'b0, alu, sd, rd, rw, mr, mw, sz, sg);
        DMemRData = rdata;
        @(negedge Clk);
        ExValid = 1'b0;
        bus = bus_now();
        stalls = 0;
        while (Stall && stalls < 40) begin
            DMemAck = 1'b0;
            stalls++;
            if (stalls == ack_at) DMemAck = 1'b1;
            @(negedge Clk);
        end
        DMemAck = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        #1;
        chk_cnt++;
        if ({Stall, bus_now(), wb_now()} !== '0)
            $display("FAIL reset_state: got %h want 0", {Stall, bus_now(), wb_now()});
        else pass_cnt++;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_nonmem();
        set_op(1'b1, 1'b0, 32'h1234_5678, '0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge Clk);
        set_op(1'b1, 1'b0, 32'hA5A5_0001, '0, 5'd6, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        chk_cnt++;
        if ({Stall, wb_now()} !== {1'b0, 4'b1100, 5'd5, 32'h1234_5678})
            $display("FAIL nonmem_wb: got %h want %h", {Stall, wb_now()},
                     {1'b0, 4'b1100, 5'd5, 32'h1234_5678});
        else pass_cnt++;
        @(negedge Clk);
        ExValid = 1'b0;
        chk_cnt++;
        if (wb_now() !== {4'b1000, 5'd6, 32'hA5A5_0001})
            $display("FAIL back_to_back_nonmem: got %h want %h", wb_now(),
                     {4'b1000, 5'd6, 32'hA5A5_0001});
        else pass_cnt++;
        @(negedge Clk);
        chk_cnt++;
        if (wb_now() !== {4'b0000, 5'd6, 32'hA5A5_0001})
            $display("FAIL nonmem_idle_hold: got %h want %h", wb_now(),
                     {4'b0000, 5'd6, 32'hA5A5_0001});
        else pass_cnt++;
    endtask

    task automatic test_loads();
        int n;
        logic [69:0] bus;
        run_access(32'h103, '0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h80AA_BBCC, 4, n, bus);
        chk_cnt++;
        if (bus !== {1'b1, 1'b0, 4'b1000, 32'h100, 32'h0})
            $display("FAIL lb_bus: got %h want %h", bus, {1'b1, 1'b0, 4'b1000, 32'h100, 32'h0});
        else pass_cnt++;
        chk_cnt++;
        if (n !== 4) $display("FAIL lb_stall_cycles: got %0d want 4", n);
        else pass_cnt++;
        chk_cnt++;
        if (wb_now() !== {4'b1100, 5'd9, 32'hFFFF_FF80})
            $display("FAIL lb_signed: got %h want %h", wb_now(), {4'b1100, 5'd9, 32'hFFFF_FF80});
        else pass_cnt++;

        run_access(32'h103, '0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h80AA_BBCC, 4, n, bus);
        chk_cnt++;
        if (wb_now() !== {4'b1100, 5'd9, 32'h0000_0080})
            $display("FAIL lbu: got %h want %h", wb_now(), {4'b1100, 5'd9, 32'h0000_0080});
        else pass_cnt++;

        run_access(32'h102, '0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h80AA_BBCC, 1, n, bus);
        chk_cnt++;
        if ({n[3:0], bus[67:64], wb_now()} !== {4'd1, 4'b1100, 4'b1100, 5'd10, 32'hFFFF_80AA})
            $display("FAIL lh_signed: got %h want %h", {n[3:0], bus[67:64], wb_now()},
                     {4'd1, 4'b1100, 4'b1100, 5'd10, 32'hFFFF_80AA});
        else pass_cnt++;

        run_access(32'h100, '0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h80AA_BB7C, 1, n, bus);
        chk_cnt++;
        if (wb_now() !== {4'b1100, 5'd11, 32'h0000_007C})
            $display("FAIL lb_lane0_positive: got %h want %h", wb_now(),
                     {4'b1100, 5'd11, 32'h0000_007C});
        else pass_cnt++;
    endtask

    task automatic test_stores();
        int n;
        logic [69:0] bus;
        run_access(32'h202, 32'h0000_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, '0, 1, n, bus);
        chk_cnt++;
        if (bus !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF})
            $display("FAIL sh_bus: got %h want %h", bus,
                     {1'b1, 1'b1, 4'b1100, 32'h200, 32'hBEEF_BEEF});
        else pass_cnt++;
        chk_cnt++;
        if ({n[3:0], WbValid, WbRegWrite, WbWriteRegister} !== {4'd1, 1'b1, 1'b0, 5'd3})
            $display("FAIL sh_wb: got %h want %h", {n[3:0], WbValid, WbRegWrite, WbWriteRegister},
                     {4'd1, 1'b1, 1'b0, 5'd3});
        else pass_cnt++;

        run_access(32'h201, 32'h1234_56AB, 5'd3, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, '0, 2, n, bus);
        chk_cnt++;
        if ({bus, WbRegWrite} !== {1'b1, 1'b1, 4'b0010, 32'h200, 32'hABAB_ABAB, 1'b0})
            $display("FAIL sb_bus: got %h want %h", {bus, WbRegWrite},
                     {1'b1, 1'b1, 4'b0010, 32'h200, 32'hABAB_ABAB, 1'b0});
        else pass_cnt++;

        run_access(32'h204, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, '0, 1, n, bus);
        chk_cnt++;
        if (bus !== {1'b1, 1'b1, 4'b1111, 32'h204, 32'hDEAD_BEEF})
            $display("FAIL sw_bus: got %h want %h", bus,
                     {1'b1, 1'b1, 4'b1111, 32'h204, 32'hDEAD_BEEF});
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        set_op(1'b1, 1'b0, 32'h106, '0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge Clk);
        ExValid = 1'b0;
        chk_cnt++;
        if ({DMemReq, Stall, WbValid, WbRegWrite, MisalignFault, BusError} !== 6'b001010)
            $display("FAIL lw_misalign: got %b want 001010",
                     {DMemReq, Stall, WbValid, WbRegWrite, MisalignFault, BusError});
        else pass_cnt++;
        @(negedge Clk);
        chk_cnt++;
        if ({DMemReq, WbValid, MisalignFault} !== 3'b000)
            $display("FAIL misalign_pulse: got %b want 000", {DMemReq, WbValid, MisalignFault});
        else pass_cnt++;
        set_op(1'b1, 1'b0, 32'h201, '0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        @(negedge Clk);
        ExValid = 1'b0;
        chk_cnt++;
        if ({DMemReq, WbValid, MisalignFault} !== 3'b011)
            $display("FAIL lh_misalign: got %b want 011", {DMemReq, WbValid, MisalignFault});
        else pass_cnt++;
        @(negedge Clk);
    endtask

    task automatic test_timeout();
        int n;
        logic [69:0] bus;
        run_access(32'h300, '0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h5555_AAAA, 0, n, bus);
        chk_cnt++;
        if (n !== TO) $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
        else pass_cnt++;
        set_op(1'b1, 1'b0, 32'hCAFE_0001, '0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        chk_cnt++;
        if ({DMemReq, WbValid, WbRegWrite, MisalignFault, BusError} !== 5'b01001)
            $display("FAIL bus_error: got %b want 01001",
                     {DMemReq, WbValid, WbRegWrite, MisalignFault, BusError});
        else pass_cnt++;
        @(negedge Clk);
        set_op(1'b1, 1'b1, 32'hBAD0_BAD0, '0, 5'd8, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        chk_cnt++;
        if (wb_now() !== {4'b1100, 5'd7, 32'hCAFE_0001})
            $display("FAIL after_timeout_accept: got %h want %h", wb_now(),
                     {4'b1100, 5'd7, 32'hCAFE_0001});
        else pass_cnt++;
        @(negedge Clk);
        ExValid = 1'b0; Flush = 1'b0;
        chk_cnt++;
        if (wb_now() !== {4'b0000, 5'd7, 32'hCAFE_0001})
            $display("FAIL flush_squash: got %h want %h", wb_now(), {4'b0000, 5'd7, 32'hCAFE_0001});
        else pass_cnt++;

        run_access(32'h400, '0, 5'd13, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h5555_AAAA, TO, n, bus);
        chk_cnt++;
        if ({n[7:0], wb_now()} !== {8'(TO), 4'b1100, 5'd13, 32'h5555_AAAA})
            $display("FAIL ack_on_last_count: got %h want %h", {n[7:0], wb_now()},
                     {8'(TO), 4'b1100, 5'd13, 32'h5555_AAAA});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        set_op(1'b1, 1'b0, 32'h500, '0, 5'd14, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge Clk);
        ExValid = 1'b0;
        chk_cnt++;
        if ({DMemReq, Stall} !== 2'b11)
            $display("FAIL pre_reset_access: got %b want 11", {DMemReq, Stall});
        else pass_cnt++;
        #2 Reset = 1'b1;
        #1;
        chk_cnt++;
        if ({DMemReq, Stall, WbValid} !== 3'b000)
            $display("FAIL reset_mid_access: got %b want 000", {DMemReq, Stall, WbValid});
        else pass_cnt++;
        @(negedge Clk);
        Reset = 1'b0;
        DMemRData = 32'h7777_7777;
        DMemAck = 1'b1;
        @(negedge Clk);
        DMemAck = 1'b0;
        chk_cnt++;
        if ({DMemReq, Stall, wb_now()} !== '0)
            $display("FAIL late_ack_ignored: got %h want 0", {DMemReq, Stall, wb_now()});
        else pass_cnt++;
        set_op(1'b1, 1'b0, 32'h0000_0042, '0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge Clk);
        ExValid = 1'b0;
        chk_cnt++;
        if (wb_now() !== {4'b1100, 5'd15, 32'h0000_0042})
            $display("FAIL post_reset_accept: got %h want %h", wb_now(),
                     {4'b1100, 5'd15, 32'h0000_0042});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
